// File: rtl/sfp_port_ctrl_if.sv
// sfp_port_ctrl_if: cage pins, management enable and status outputs of one SFP port
interface sfp_port_ctrl_if;
    logic       mod_abs_i;
    logic       rxlos_i;
    logic       tx_fault_i;
    logic       tx_en_i;
    logic       tx_dis_o;
    logic       present_o;
    logic       link_up_o;
    logic       fault_o;
    logic [2:0] state_o;
    logic [1:0] retry_cnt_o;

    modport master (
        output mod_abs_i, rxlos_i, tx_fault_i, tx_en_i,
        input  tx_dis_o, present_o, link_up_o, fault_o, state_o, retry_cnt_o
    );

    modport slave (
        input  mod_abs_i, rxlos_i, tx_fault_i, tx_en_i,
        output tx_dis_o, present_o, link_up_o, fault_o, state_o, retry_cnt_o
    );
endinterface

// File: rtl/sfp_port_ctrl.sv
// sfp_port_ctrl: per-cage SFP pin conditioning, TX enable sequencing and bounded fault recovery
module sfp_port_ctrl #(
    parameter int DEBOUNCE_CYC    = 1000,
    parameter int INIT_CYC        = 30000000,
    parameter int TXDIS_PULSE_CYC = 1000,
    parameter int MAX_RETRIES     = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    sfp_port_ctrl_if.slave  bus
);
    localparam int MAX_T = (INIT_CYC > TXDIS_PULSE_CYC)
                         ? ((INIT_CYC > DEBOUNCE_CYC) ? INIT_CYC : DEBOUNCE_CYC)
                         : ((TXDIS_PULSE_CYC > DEBOUNCE_CYC) ? TXDIS_PULSE_CYC : DEBOUNCE_CYC);
    localparam int TMR_W = $clog2(MAX_T + 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(MAX_T);
    localparam logic [TMR_W-1:0] INIT_END  = TMR_W'(INIT_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_END = TMR_W'(TXDIS_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] DB_END    = TMR_W'(DEBOUNCE_CYC - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ABSENT    = 3'd0,
        INIT      = 3'd1,
        ACTIVE    = 3'd2,
        FAULT_RST = 3'd3,
        LOCKOUT   = 3'd4
    } state_e;

    // bit 0 = mod_abs, bit 1 = rxlos, bit 2 = tx_fault
    logic [2:0]            sync1_q, sync2_q;
    logic [1:0]            db_q, db_d;
    logic [1:0][TMR_W-1:0] cnt_q, cnt_d;
    state_e                state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [1:0]            retry_q, retry_d;
    logic                  tx_dis_q, tx_dis_d;
    logic                  present_q, present_d;
    logic                  link_q, link_d;
    logic                  fault_q, fault_d;
    logic                  fault_req;

    assign fault_req = sync2_q[2] & bus.tx_en_i;

    // two-stage synchroniser on the asynchronous cage pins; resets to absent/los/fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= {bus.tx_fault_i, bus.rxlos_i, bus.mod_abs_i};
            sync2_q <= sync1_q;
        end
    end

    // debounce mod_abs and rxlos: flip only after DEBOUNCE_CYC consecutive differing samples
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_END) db_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + TMR_W'(1);
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ABSENT;
        else state_q <= state_d;
    end

    // next state; module removal overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ABSENT:    if (!db_q[0]) state_d = INIT;
            INIT:      if (tmr_q == INIT_END) state_d = ACTIVE;
            ACTIVE:    if (fault_req) state_d = (retry_q == RETRY_MAX) ? LOCKOUT : FAULT_RST;
            FAULT_RST: if (tmr_q == PULSE_END) state_d = INIT;
            LOCKOUT:   if (!bus.tx_en_i) state_d = INIT;
            default:   state_d = ABSENT;
        endcase
        if (db_q[0]) state_d = ABSENT;
    end

    // shared timer restarts on every state change; retry count clears on removal or acknowledge
    always_comb begin
        tmr_d   = (state_d != state_q) ? '0 : (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);
        retry_d = (state_d == ABSENT || (state_q == LOCKOUT && state_d == INIT)) ? 2'd0
                : (state_q == ACTIVE && state_d == FAULT_RST && retry_q != RETRY_MAX) ? retry_q + 2'd1
                : retry_q;
    end

    // outputs derived from the next state so they update on the same edge as the state register
    always_comb begin
        tx_dis_d  = (state_d == INIT || state_d == ACTIVE) ? ~bus.tx_en_i : 1'b1;
        present_d = ~db_d[0];
        link_d    = (state_d == ACTIVE) & ~db_d[1];
        fault_d   = (state_d == LOCKOUT);
    end

    // datapath and output registers; laser held off while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= 2'b11;
            cnt_q     <= '0;
            tmr_q     <= '0;
            retry_q   <= '0;
            tx_dis_q  <= 1'b1;
            present_q <= 1'b0;
            link_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            retry_q   <= retry_d;
            tx_dis_q  <= tx_dis_d;
            present_q <= present_d;
            link_q    <= link_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.tx_dis_o    = tx_dis_q;
    assign bus.present_o   = present_q;
    assign bus.link_up_o   = link_q;
    assign bus.fault_o     = fault_q;
    assign bus.state_o     = state_q;
    assign bus.retry_cnt_o = retry_q;
endmodule
